countdown_sequencer: RTL and testbench

//  Controller for the N-bit down counter of the countdown timer.
//  - Prescales the board clock into a tick and issues one-cycle count enables.
//  - Sequences start/pause/reload requests from user buttons.
//  - Halts the countdown at zero and raises an expired flag.
//  - Sits between the button inputs and the counter's enable/load inputs.

---
 rtl/countdown_if.sv | 25 ++
 rtl/countdown_sequencer.sv | 111 +++++++++++
 tb/tb_countdown_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_if.sv
// Request/feedback bundle between the button front-end, the countdown
// sequencer and the down counter it drives.
interface countdown_if #(
    parameter int N = 6
);
    logic         i_start;
    logic         i_pause;
    logic         i_reload;
    logic [N-1:0] i_count_value;
    logic         o_cnt_en;
    logic         o_cnt_load;
    logic [N-1:0] o_load_value;
    logic         o_expired;
    logic [1:0]   o_state;

    modport master (
        output i_start, i_pause, i_reload, i_count_value,
        input  o_cnt_en, o_cnt_load, o_load_value, o_expired, o_state
    );

    modport slave (
        input  i_start, i_pause, i_reload, i_count_value,
        output o_cnt_en, o_cnt_load, o_load_value, o_expired, o_state
    );
endinterface

// File: rtl/countdown_sequencer.sv
// Countdown timer controller: prescales the clock into count enables and
// sequences start/pause/reload button requests for an external down counter.
module countdown_sequencer #(
    parameter int N        = 6,
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int LOAD_VAL = 40
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    countdown_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_RUN     = 2'b01;
    localparam logic [1:0] S_PAUSE   = 2'b10;
    localparam logic [1:0] S_EXPIRED = 2'b11;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          r_prev_start;
    logic          r_prev_pause;
    logic          r_prev_reload;
    logic          r_cnt_en;
    logic          w_cnt_en_next;
    logic          r_cnt_load;
    logic          w_cnt_load_next;

    logic w_ev_start;
    logic w_ev_pause;
    logic w_ev_reload;
    logic w_zero;

    assign w_ev_start  = bus.i_start  & ~r_prev_start;
    assign w_ev_pause  = bus.i_pause  & ~r_prev_pause;
    assign w_ev_reload = bus.i_reload & ~r_prev_reload;
    assign w_zero      = (bus.i_count_value == '0);

    always_comb begin
        w_state_next    = r_state;
        w_presc_next    = r_presc;
        w_cnt_en_next   = 1'b0;
        w_cnt_load_next = 1'b0;
        // Reload wins in every state; it also parks the prescaler at zero.
        if (w_ev_reload) begin
            w_state_next    = S_IDLE;
            w_presc_next    = '0;
            w_cnt_load_next = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ev_start) begin
                        w_state_next = S_RUN;
                        w_presc_next = '0;
                    end
                end
                S_RUN: begin
                    if (w_ev_pause) begin
                        w_state_next = S_PAUSE;
                    end else if (w_zero) begin
                        // Stop before the counter could ever wrap below zero.
                        w_state_next = S_EXPIRED;
                    end else if (r_presc == PRESC_LAST) begin
                        w_presc_next  = '0;
                        w_cnt_en_next = 1'b1;
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (w_ev_start) begin
                        w_state_next = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_presc       <= '0;
            r_prev_start  <= 1'b0;
            r_prev_pause  <= 1'b0;
            r_prev_reload <= 1'b0;
            r_cnt_en      <= 1'b0;
            r_cnt_load    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_presc       <= w_presc_next;
            r_prev_start  <= bus.i_start;
            r_prev_pause  <= bus.i_pause;
            r_prev_reload <= bus.i_reload;
            r_cnt_en      <= w_cnt_en_next;
            r_cnt_load    <= w_cnt_load_next;
        end
    end

    assign bus.o_cnt_en     = r_cnt_en;
    assign bus.o_cnt_load   = r_cnt_load;
    assign bus.o_load_value = N'(LOAD_VAL);
    assign bus.o_expired    = (r_state == S_EXPIRED);
    assign bus.o_state      = r_state;
endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios plus a randomized run
// checked against an abstract mode/elapsed-time reference model.
module tb_countdown_sequencer;
    localparam int N        = 6;
    localparam int CLK_HZ   = 4;
    localparam int TICK_HZ  = 1;
    localparam int LOAD_VAL = 40;
    localparam int DIV      = CLK_HZ / TICK_HZ;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    countdown_if #(.N(N)) bus ();

    countdown_sequencer #(
        .N(N), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LOAD_VAL(LOAD_VAL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a mode plus the number of running cycles since the last tick.
    typedef enum int {M_IDLE = 0, M_RUN, M_PAUSE, M_EXPIRED} mode_t;
    typedef struct packed {
        mode_t mode;
        int    elapsed;
        bit    ps;
        bit    pp;
        bit    pr;
        bit    en;
        bit    load;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t cur, bit s, bit p, bit r, bit zero);
        model_t nx;
        bit es, ep, er;
        nx = cur;
        es = s && !cur.ps;
        ep = p && !cur.pp;
        er = r && !cur.pr;
        nx.ps = s; nx.pp = p; nx.pr = r;
        nx.en = 1'b0; nx.load = 1'b0;
        if (er) begin
            nx.load = 1'b1; nx.mode = M_IDLE; nx.elapsed = 0;
        end else if (cur.mode == M_IDLE && es) begin
            nx.mode = M_RUN; nx.elapsed = 0;
        end else if (cur.mode == M_RUN) begin
            if (ep) nx.mode = M_PAUSE;
            else if (zero) nx.mode = M_EXPIRED;
            else begin
                nx.elapsed = cur.elapsed + 1;
                if (nx.elapsed == DIV) begin
                    nx.en = 1'b1; nx.elapsed = 0;
                end
            end
        end else if (cur.mode == M_PAUSE && es) begin
            nx.mode = M_RUN;
        end
        return nx;
    endfunction

    function automatic logic [1:0] mode_code(mode_t md);
        case (md)
            M_IDLE:  return 2'b00;
            M_RUN:   return 2'b01;
            M_PAUSE: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_next(m, bus.i_start, bus.i_pause, bus.i_reload, bus.i_count_value == '0);
    end

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (bus.o_state !== 2'b00 || bus.o_cnt_en !== 1'b0 || bus.o_cnt_load !== 1'b0 || bus.o_expired !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got st=%b en=%b ld=%b ex=%b want 00/0/0/0", bus.o_state, bus.o_cnt_en, bus.o_cnt_load, bus.o_expired);
        end
        rst_n = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.o_state !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_prerun got st=%b want 01", bus.o_state);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.o_state !== 2'b00 || bus.o_cnt_en !== 1'b0 || bus.o_cnt_load !== 1'b0 || bus.o_expired !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got st=%b en=%b ld=%b ex=%b want 00/0/0/0", bus.o_state, bus.o_cnt_en, bus.o_cnt_load, bus.o_expired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.o_state !== 2'b00 || bus.o_cnt_en !== 1'b0 || bus.o_cnt_load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got st=%b en=%b ld=%b want 00/0/0", bus.o_state, bus.o_cnt_en, bus.o_cnt_load);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_reload_idle();
        bus.i_reload = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_cnt_load !== (i == 0) || bus.o_state !== 2'b00 || bus.o_load_value !== 6'd40) begin
                n_fail++;
                $display("FAIL reload_idle i=%0d got ld=%b st=%b lv=%0d want %0d/00/40", i, bus.o_cnt_load, bus.o_state, bus.o_load_value, (i == 0));
            end
        end
        bus.i_reload = 1'b0;
        @(negedge clk);
        $display("[TB] test_reload_idle done");
    endtask

    task automatic test_run_and_pause();
        bus.i_count_value = 6'd5;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        n_tests++;
        if (bus.o_state !== 2'b01 || bus.o_cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL run_enter got st=%b en=%b want 01/0", bus.o_state, bus.o_cnt_en);
        end
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_cnt_en !== (k % DIV == 0 && k <= 16) || bus.o_cnt_load !== 1'b0 || bus.o_state !== 2'b01) begin
                n_fail++;
                $display("FAIL run_tick k=%0d got en=%b ld=%b st=%b want en=%0d", k, bus.o_cnt_en, bus.o_cnt_load, bus.o_state, (k % DIV == 0));
            end
        end
        bus.i_pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_state !== 2'b10 || bus.o_cnt_en !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold i=%0d got st=%b en=%b want 10/0", i, bus.o_state, bus.o_cnt_en);
            end
        end
        bus.i_pause = 1'b0;
        bus.i_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            n_tests++;
            if (bus.o_state !== 2'b01 || bus.o_cnt_en !== (i == 2)) begin
                n_fail++;
                $display("FAIL resume i=%0d got st=%b en=%b want 01/%0d", i, bus.o_state, bus.o_cnt_en, (i == 2));
            end
        end
        $display("[TB] test_run_and_pause done");
    endtask

    task automatic test_expire();
        bus.i_count_value = 6'd0;
        @(negedge clk);
        n_tests++;
        if (bus.o_state !== 2'b11 || bus.o_expired !== 1'b1 || bus.o_cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL expire_enter got st=%b ex=%b en=%b want 11/1/0", bus.o_state, bus.o_expired, bus.o_cnt_en);
        end
        bus.i_start = 1'b1;
        bus.i_pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_state !== 2'b11 || bus.o_expired !== 1'b1 || bus.o_cnt_en !== 1'b0) begin
                n_fail++;
                $display("FAIL expire_hold i=%0d got st=%b ex=%b en=%b want 11/1/0", i, bus.o_state, bus.o_expired, bus.o_cnt_en);
            end
        end
        bus.i_start = 1'b0;
        bus.i_pause = 1'b0;
        bus.i_reload = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_state !== 2'b00 || bus.o_expired !== 1'b0 || bus.o_cnt_load !== (i == 0)) begin
                n_fail++;
                $display("FAIL expire_reload i=%0d got st=%b ex=%b ld=%b want 00/0/%0d", i, bus.o_state, bus.o_expired, bus.o_cnt_load, (i == 0));
            end
        end
        bus.i_reload = 1'b0;
        bus.i_count_value = 6'd5;
        @(negedge clk);
        $display("[TB] test_expire done");
    endtask

    task automatic test_simultaneous();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_pause = 1'b1;
        bus.i_reload = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.o_state !== 2'b00 || bus.o_cnt_load !== 1'b1 || bus.o_cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL simul got st=%b ld=%b en=%b want 00/1/0", bus.o_state, bus.o_cnt_load, bus.o_cnt_en);
        end
        bus.i_start = 1'b0;
        bus.i_pause = 1'b0;
        bus.i_reload = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.o_state !== 2'b00 || bus.o_cnt_load !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_after got st=%b ld=%b want 00/0", bus.o_state, bus.o_cnt_load);
        end
        $display("[TB] test_simultaneous done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_state !== mode_code(m.mode) || bus.o_cnt_en !== m.en || bus.o_cnt_load !== m.load ||
                bus.o_expired !== (m.mode == M_EXPIRED) || bus.o_load_value !== 6'd40 ||
                (bus.o_cnt_en && bus.o_cnt_load)) begin
                n_fail++;
                $display("FAIL random c=%0d got st=%b en=%b ld=%b ex=%b want st=%b en=%b ld=%b", c,
                         bus.o_state, bus.o_cnt_en, bus.o_cnt_load, bus.o_expired, mode_code(m.mode), m.en, m.load);
            end
            bus.i_start  = ($urandom_range(0, 2) == 0);
            bus.i_pause  = ($urandom_range(0, 5) == 0);
            bus.i_reload = ($urandom_range(0, 11) == 0);
            bus.i_count_value = ($urandom_range(0, 24) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_pause = 1'b0;
        bus.i_reload = 1'b0;
        bus.i_count_value = 6'd5;
        test_reset();
        test_reload_idle();
        test_run_and_pause();
        test_expire();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
